hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Parametrised HI/LO register pair with an integrated iterative multiply/divide engine for the MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU/MADD/MSUB over WIDTH cycles, and MTHI/MTLO in a single cycle.
- Holds architectural HI/LO with gated read ports.
- Raises Busy so the controller can stall MFHI/MFLO and further HI/LO ops.

Parameters:
WIDTH, 32, operand and HI/LO register width (>=4)
CNT_W, $clog2(WIDTH)+1, derived localparam, iteration counter width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  request; accepted only when Busy=0
Op  in  3  operation code (package encoding)
OperandA  in  WIDTH  rs: multiplicand/dividend; data for MTHI/MTLO
OperandB  in  WIDTH  rt: multiplier/divisor
HiRead  in  1  HiOut enable
LoRead  in  1  LoOut enable
HiOut  out  WIDTH  HiRead ? HI : 0 (combinational)
LoOut  out  WIDTH  LoRead ? LO : 0 (combinational)
Busy  out  1  engine active
Done  out  1  one-cycle completion pulse
DivByZero  out  1  valid with Done; divisor was zero

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high on port Reset.
- Reset values: HI=0, LO=0, state=IDLE, Busy=0, Done=0, DivByZero=0, counter=0.
- Reset mid-operation: aborts immediately. HI/LO are cleared and no Done is issued.
- Op encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD (signed), 101 MSUB (signed), 110 MTHI, 111 MTLO.
- Acceptance: Start=1 && Busy=0 at a rising edge.
- Start while Busy=1 is ignored entirely, including MTHI/MTLO.
- MTHI/MTLO:
  - HI (or LO) <= OperandA at the accepting edge; the other register is unchanged.
  - Busy stays 0 and no Done pulse is issued.
  - The new value is visible on the outputs the following cycle.
- States: IDLE -> CALC (exactly WIDTH cycles) -> FINISH (1 cycle) -> IDLE.
  - Accepting edge: latch |A| and |B| (or raw values for unsigned ops), the sign flags and the op; state <= CALC, counter <= 0.
  - CALC, multiply: one shift-add step per cycle on a 2*WIDTH-bit accumulator.
  - CALC, divide: one restoring shift-subtract step per cycle.
  - Counter == WIDTH-1 -> FINISH.
  - FINISH: apply sign correction and the MADD/MSUB accumulate; write HI/LO at the end of the cycle.
  - Done=1 and Busy=1 during FINISH. Busy=0 from the next cycle, when the new HI/LO are visible.
- Latency: Busy high for WIDTH+1 cycles after the accepting edge.
- Signed multiply:
  - Product = (signA XOR signB) ? -P : P, with P the unsigned product of the magnitudes.
  - Result is 2*WIDTH bits; HI = upper half, LO = lower half.
- MADD/MSUB: {HI,LO} <= {HI,LO} +/- signed product, modulo 2^(2*WIDTH). The HI/LO values used are those at FINISH.
- Signed divide:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Overflow: MIN_INT / -1 gives LO=MIN_INT, HI=0 (falls out of wrap-around magnitude arithmetic).
- Divide by zero:
  - Runs full latency.
  - HI = OperandA as latched, LO = all ones.
  - DivByZero=1 with Done.
  - DivByZero is 0 on every other cycle.
- HiOut/LoOut always reflect the committed HI/LO. They never show intermediate values.

Decomposition:
- Package hilo_pkg:
  - Op code localparams: OP_MULT … OP_MTLO.
  - State encodings: ST_IDLE, ST_CALC, ST_FINISH.
- One natural sub-module: hilo_iter_core (WIDTH).
  - Implements the unsigned shift-add and restoring-division step datapath: accumulator, remainder, counter.
  - hilo_muldiv_unit keeps the FSM, sign handling, MADD/MSUB and the HI/LO registers.

Test Plan:
1. MTHI 0x12345678, then MTLO 0x9ABCDEF0, reads=1 -> HiOut=0x12345678, LoOut=0x9ABCDEF0, Busy never set. Reads=0 -> both outputs 0.
2. MULT A=0xFFFFFFFD (-3), B=7 -> Busy 33 cycles, Done in cycle 33, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT 0x80000000 x 0xFFFFFFFF -> HI=0x00000000, LO=0x80000000.
4. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> DivByZero=1 with Done, HI=7, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
5. MTHI 0, MTLO 10, MADD 3x4 -> LO=22, HI=0. Then MSUB 5x5 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
6. Start MULT, pulse Start with MTLO 0x55 in CALC cycle 5 -> MTLO ignored, LO = product only. Assert Reset in CALC cycle 10 -> Busy=0 and HI=LO=0 immediately, no Done; next Start accepted normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared op codes and FSM state encoding for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_muldiv_unit_core.sv
// Unsigned iterative engine: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on a shared 2*WIDTH accumulator.
module hilo_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  // Low half holds multiplier (consumed LSB first) or dividend/quotient;
  // high half holds the partial product or the running remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div) begin
      if (div_ge) acc_nxt = {div_diff, acc_q[WIDTH-2:0], 1'b1};
      else        acc_nxt = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk) begin
    if (load) begin
      acc_q  <= {{WIDTH{1'b0}}, a_mag};
      opnd_q <= b_mag;
    end else if (step) begin
      acc_q  <= acc_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + CNT_W'(1);
  end

  assign acc  = acc_q;
  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// MIPS HI/LO register pair with an iterative MULT/DIV/MADD/MSUB engine and
// single-cycle MTHI/MTLO; Busy lets the controller stall dependent ops.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiRead,
  input  logic             LoRead,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   hi, lo;
  logic [2:0]         op_q;
  logic               sign_a_q, sign_b_q, b_zero_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               accept, engine_op, signed_op, sign_a, sign_b, is_div_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] core_acc;
  logic               core_last;

  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [2*WIDTH-1:0] hilo_s;
  logic signed [WIDTH-1:0]   quo_s, rem_s;
  logic [2*WIDTH-1:0]        result;

  assign accept    = Start && (state == ST_IDLE);
  assign engine_op = (Op != OP_MTHI) && (Op != OP_MTLO);
  assign signed_op = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
  assign sign_a    = signed_op && OperandA[WIDTH-1];
  assign sign_b    = signed_op && OperandB[WIDTH-1];
  assign a_mag     = sign_a ? -OperandA : OperandA;
  assign b_mag     = sign_b ? -OperandB : OperandB;
  assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);

  hilo_iter_core #(.WIDTH(WIDTH)) u_core (
    .Clk    (Clk),
    .Reset  (Reset),
    .load   (accept && engine_op),
    .step   (state == ST_CALC),
    .is_div (is_div_q),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (core_acc),
    .last   (core_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept && engine_op) state_nxt = ST_CALC;
      ST_CALC:   if (core_last) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (accept && engine_op) begin
      op_q     <= Op;
      sign_a_q <= sign_a;
      sign_b_q <= sign_b;
      b_zero_q <= (OperandB == '0);
      a_raw_q  <= OperandA;
    end
  end

  // FINISH: sign correction, accumulate and divide-by-zero override
  always_comb begin
    prod_s = $signed(core_acc);
    if (sign_a_q ^ sign_b_q) prod_s = -prod_s;
    hilo_s = $signed({hi, lo});
    quo_s  = $signed(core_acc[WIDTH-1:0]);
    rem_s  = $signed(core_acc[2*WIDTH-1:WIDTH]);
    if (sign_a_q ^ sign_b_q) quo_s = -quo_s;
    if (sign_a_q)            rem_s = -rem_s;
    case (op_q)
      OP_MADD: result = hilo_s + prod_s;
      OP_MSUB: result = hilo_s - prod_s;
      OP_DIV, OP_DIVU: begin
        if (b_zero_q) result = {a_raw_q, {WIDTH{1'b1}}};
        else          result = {rem_s, quo_s};
      end
      default: result = prod_s;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FINISH) begin
      hi <= result[2*WIDTH-1:WIDTH];
      lo <= result[WIDTH-1:0];
    end else if (accept && (Op == OP_MTHI)) begin
      hi <= OperandA;
    end else if (accept && (Op == OP_MTLO)) begin
      lo <= OperandA;
    end
  end

  assign HiOut     = HiRead ? hi : '0;
  assign LoOut     = LoRead ? lo : '0;
  assign Busy      = (state != ST_IDLE);
  assign Done      = (state == ST_FINISH);
  assign DivByZero = (state == ST_FINISH) && is_div_q && b_zero_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed table-driven bench for hilo_muldiv_unit plus hand-written
// sequences for Start-while-busy and mid-operation reset.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start, HiRead, LoRead;
  logic [2:0]   Op;
  logic [W-1:0] OperandA, OperandB;
  logic [W-1:0] HiOut, LoOut;
  logic         Busy, Done, DivByZero;

  int total = 0;
  int bad   = 0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .HiRead    (HiRead),
    .LoRead    (LoRead),
    .HiOut     (HiOut),
    .LoOut     (LoOut),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[16];

  // Issues one op and follows it until Busy drops (bounded).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_n, output int done_n, output int done_at,
                        output int dz_seen, output int stray);
    busy_n = 0; done_n = 0; done_at = 0; dz_seen = 0; stray = 0;
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(negedge Clk);
    Start = 1'b0;
    if (Done) done_n++;
    while (Busy && busy_n < 100) begin
      busy_n++;
      if (Done) begin
        done_n++;
        done_at = busy_n;
        if (DivByZero) dz_seen = 1;
      end else if (DivByZero) begin
        stray++;
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    int busy_n, done_n, done_at, dz_seen, stray;
    bit engine;

    vecs[0]  = '{OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 1'b0};
    vecs[1]  = '{OP_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 1'b0};
    vecs[2]  = '{OP_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[4]  = '{OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[8]  = '{OP_MTHI,  32'h0,        32'h0,        32'h00000000, 32'h80000000, 1'b0};
    vecs[9]  = '{OP_MTLO,  32'd10,       32'h0,        32'h00000000, 32'd10,       1'b0};
    vecs[10] = '{OP_MADD,  32'd3,        32'd4,        32'h00000000, 32'd22,       1'b0};
    vecs[11] = '{OP_MSUB,  32'd5,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[12] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[13] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[14] = '{OP_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[15] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

    Reset = 1'b1; Start = 1'b0; Op = 3'b000; OperandA = '0; OperandB = '0;
    HiRead = 1'b1; LoRead = 1'b1;
    repeat (2) @(negedge Clk);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_dz",   DivByZero, 0);
    check("reset_hi",   HiOut, 0);
    check("reset_lo",   LoOut, 0);
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, busy_n, done_n, done_at, dz_seen, stray);
      engine = (vecs[i].op != OP_MTHI) && (vecs[i].op != OP_MTLO);
      check($sformatf("v%0d_busy_cycles", i), busy_n, engine ? W + 1 : 0);
      check($sformatf("v%0d_done_count", i), done_n, engine ? 1 : 0);
      if (engine) check($sformatf("v%0d_done_cycle", i), done_at, W + 1);
      check($sformatf("v%0d_divbyzero", i), dz_seen, vecs[i].dz);
      check($sformatf("v%0d_dz_stray", i), stray, 0);
      check($sformatf("v%0d_hi", i), HiOut, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LoOut, vecs[i].lo);
    end

    // Read gating: HI=1, LO=0 committed from the last vector
    HiRead = 1'b0; LoRead = 1'b0; #1;
    check("gate_hi_off", HiOut, 0);
    check("gate_lo_off", LoOut, 0);
    HiRead = 1'b1; #1;
    check("gate_hi_on", HiOut, 1);
    LoRead = 1'b1;

    // MTLO while busy must be ignored; outputs hold committed values mid-op
    @(negedge Clk);
    Start = 1'b1; Op = OP_MULT; OperandA = 32'd6; OperandB = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    check("seqA_busy_c5", Busy, 1);
    Start = 1'b1; Op = OP_MTLO; OperandA = 32'h55;
    @(negedge Clk);
    Start = 1'b0;
    check("seqA_hi_mid", HiOut, 1);
    check("seqA_lo_mid", LoOut, 0);
    busy_n = 0;
    while (Busy && busy_n < 100) begin busy_n++; @(negedge Clk); end
    check("seqA_busy_timeout", busy_n < 100, 1);
    check("seqA_hi", HiOut, 0);
    check("seqA_lo", LoOut, 42);

    // Reset in CALC cycle 10 aborts immediately with no Done
    @(negedge Clk);
    Start = 1'b1; Op = OP_MULTU; OperandA = 32'hFFFF; OperandB = 32'hFFFF;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    check("seqB_busy_c10", Busy, 1);
    Reset = 1'b1; #1;
    check("seqB_rst_busy", Busy, 0);
    check("seqB_rst_done", Done, 0);
    check("seqB_rst_hi", HiOut, 0);
    check("seqB_rst_lo", LoOut, 0);
    @(negedge Clk);
    Reset = 1'b0;
    done_n = 0;
    repeat (3) begin @(negedge Clk); if (Done || Busy) done_n++; end
    check("seqB_no_done_after", done_n, 0);

    run_op(OP_DIVU, 32'd100, 32'd7, busy_n, done_n, done_at, dz_seen, stray);
    check("seqB_restart_busy", busy_n, W + 1);
    check("seqB_restart_done", done_n, 1);
    check("seqB_restart_hi", HiOut, 2);
    check("seqB_restart_lo", LoOut, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
